// File: rtl/unified_mem.sv
// Byte-addressed memory with independent fetch (32b) and data (64b, lane-strobed) ports.
// Latency: WAIT+1 cycles from acceptance to the one-cycle response pulse, per port.
// Backpressure: each port accepts only when idle; one outstanding transaction per port.
module unified_mem #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
    parameter int          AW        = 27,
    parameter int          WAIT      = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        i_req_ready,
    input  logic [63:0] i_req_addr,
    output logic        i_rsp_valid,
    output logic [31:0] i_rsp_instr,
    output logic        i_rsp_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_req_wr,
    input  logic [7:0]  d_req_strb,
    input  logic [63:0] d_req_addr,
    input  logic [63:0] d_req_wdata,
    output logic        d_rsp_valid,
    output logic [63:0] d_rsp_rdata,
    output logic        d_rsp_err
);

    localparam int          DEPTH    = 2 ** AW;
    localparam logic [3:0]  CNT_LOAD = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);
    localparam logic [AW:0] TOP_OFF  = (AW+1)'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    logic [7:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Fetch port
    // ------------------------------------------------------------------
    state_t        i_state, i_state_nxt;
    logic [3:0]    i_cnt;
    logic [63:0]   i_addr_q;
    logic          i_go;
    logic [63:0]   i_addr_eff;
    logic [AW-1:0] i_off;
    logic          i_err_c;
    logic [31:0]   i_instr_c;
    logic [31:0]   i_instr_q;
    logic          i_err_q;

    assign i_req_ready = (i_state == S_IDLE);
    assign i_rsp_valid = (i_state == S_RESP);
    assign i_rsp_instr = i_rsp_valid ? i_instr_q : 32'h0;
    assign i_rsp_err   = i_rsp_valid & i_err_q;

    always_comb begin
        i_state_nxt = i_state;
        i_go        = 1'b0;
        case (i_state)
            S_IDLE: if (i_req_valid) begin
                if (WAIT == 0) begin
                    i_state_nxt = S_RESP;
                    i_go        = 1'b1;
                end else begin
                    i_state_nxt = S_WAIT;
                end
            end
            S_WAIT: if (i_cnt == 4'd0) begin
                i_state_nxt = S_RESP;
                i_go        = 1'b1;
            end
            default: i_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_state  <= S_IDLE;
            i_cnt    <= 4'd0;
            i_addr_q <= 64'h0;
        end else begin
            i_state <= i_state_nxt;
            if (i_req_valid && i_req_ready) begin
                i_addr_q <= i_req_addr;
                i_cnt    <= CNT_LOAD;
            end else if (i_state == S_WAIT && i_cnt != 4'd0) begin
                i_cnt <= i_cnt - 4'd1;
            end
        end
    end

    // With WAIT==0 the array is read in the acceptance cycle, before capture.
    assign i_addr_eff = (i_state == S_IDLE) ? i_req_addr : i_addr_q;
    assign i_off      = i_addr_eff[AW-1:0];
    assign i_err_c    = (i_addr_eff[63:AW] != BASE_ADDR[63:AW])
                      || (i_addr_eff[1:0] != 2'b00)
                      || (({1'b0, i_off} + (AW+1)'(3)) > TOP_OFF);
    assign i_instr_c  = {mem[i_off + AW'(3)], mem[i_off + AW'(2)],
                         mem[i_off + AW'(1)], mem[i_off]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_instr_q <= 32'h0;
            i_err_q   <= 1'b0;
        end else if (i_go) begin
            i_err_q   <= i_err_c;
            i_instr_q <= i_err_c ? 32'h0 : i_instr_c;
        end
    end

    // ------------------------------------------------------------------
    // Data port
    // ------------------------------------------------------------------
    state_t        d_state, d_state_nxt;
    logic [3:0]    d_cnt;
    logic [63:0]   d_addr_q;
    logic          d_wr_q;
    logic [7:0]    d_strb_q;
    logic [63:0]   d_wdata_q;
    logic          d_go;
    logic [63:0]   d_addr_eff;
    logic          d_wr_eff;
    logic [7:0]    d_strb_eff;
    logic [63:0]   d_wdata_eff;
    logic [AW-1:0] d_off;
    logic [7:0]    d_oob;
    logic          d_err_c;
    logic [63:0]   d_rdata_c;
    logic [63:0]   d_rdata_q;
    logic          d_err_q;

    assign d_req_ready = (d_state == S_IDLE);
    assign d_rsp_valid = (d_state == S_RESP);
    assign d_rsp_rdata = d_rsp_valid ? d_rdata_q : 64'h0;
    assign d_rsp_err   = d_rsp_valid & d_err_q;

    always_comb begin
        d_state_nxt = d_state;
        d_go        = 1'b0;
        case (d_state)
            S_IDLE: if (d_req_valid) begin
                if (WAIT == 0) begin
                    d_state_nxt = S_RESP;
                    d_go        = 1'b1;
                end else begin
                    d_state_nxt = S_WAIT;
                end
            end
            S_WAIT: if (d_cnt == 4'd0) begin
                d_state_nxt = S_RESP;
                d_go        = 1'b1;
            end
            default: d_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_state   <= S_IDLE;
            d_cnt     <= 4'd0;
            d_addr_q  <= 64'h0;
            d_wr_q    <= 1'b0;
            d_strb_q  <= 8'h0;
            d_wdata_q <= 64'h0;
        end else begin
            d_state <= d_state_nxt;
            if (d_req_valid && d_req_ready) begin
                d_addr_q  <= d_req_addr;
                d_wr_q    <= d_req_wr;
                d_strb_q  <= d_req_strb;
                d_wdata_q <= d_req_wdata;
                d_cnt     <= CNT_LOAD;
            end else if (d_state == S_WAIT && d_cnt != 4'd0) begin
                d_cnt <= d_cnt - 4'd1;
            end
        end
    end

    assign d_addr_eff  = (d_state == S_IDLE) ? d_req_addr  : d_addr_q;
    assign d_wr_eff    = (d_state == S_IDLE) ? d_req_wr    : d_wr_q;
    assign d_strb_eff  = (d_state == S_IDLE) ? d_req_strb  : d_strb_q;
    assign d_wdata_eff = (d_state == S_IDLE) ? d_req_wdata : d_wdata_q;
    assign d_off       = d_addr_eff[AW-1:0];

    // Lanes past the top byte flag an error instead of wrapping to offset 0.
    always_comb begin
        d_oob     = 8'h0;
        d_rdata_c = 64'h0;
        for (int i = 0; i < 8; i++) begin
            d_oob[i] = ({1'b0, d_off} + (AW+1)'(i)) > TOP_OFF;
            d_rdata_c[8*i +: 8] = d_strb_eff[i] ? mem[d_off + AW'(i)] : 8'h00;
        end
    end

    assign d_err_c = (d_addr_eff[63:AW] != BASE_ADDR[63:AW]) || ((d_strb_eff & d_oob) != 8'h0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_rdata_q <= 64'h0;
            d_err_q   <= 1'b0;
        end else if (d_go) begin
            d_err_q   <= d_err_c;
            d_rdata_q <= (d_err_c || d_wr_eff) ? 64'h0 : d_rdata_c;
        end
    end

    // Array is never reset; rst_n gates the commit so an in-flight write is dropped.
    always_ff @(posedge clk) begin
        if (d_go && rst_n && d_wr_eff && !d_err_c) begin
            for (int i = 0; i < 8; i++) begin
                if (d_strb_eff[i]) begin
                    mem[d_off + AW'(i)] <= d_wdata_eff[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_unified_mem.sv
// Directed bench for unified_mem: three instances (WAIT=0/3/2) with a 64 KiB array each
// so the top-of-array boundary sits at 0x8000_FFFC.
module tb_unified_mem;

    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
    localparam logic [63:0] TOPW = BASE + 64'h0000_FFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [63:0] i_req_addr, d_req_addr, d_req_wdata;
    logic        d_req_wr;
    logic [7:0]  d_req_strb;
    logic        i_vld0, d_vld0, i_vld3, d_vld3, i_vld2, d_vld2;

    logic        i_rdy0, i_rv0, i_err0, d_rdy0, d_rv0, d_err0;
    logic [31:0] i_ins0;
    logic [63:0] d_rd0;
    logic        i_rdy3, i_rv3, i_err3, d_rdy3, d_rv3, d_err3;
    logic [31:0] i_ins3;
    logic [63:0] d_rd3;
    logic        i_rdy2, i_rv2, i_err2, d_rdy2, d_rv2, d_err2;
    logic [31:0] i_ins2;
    logic [63:0] d_rd2;

    int checks = 0;
    int errors = 0;

    unified_mem #(.BASE_ADDR(BASE), .AW(16), .WAIT(0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_vld0), .i_req_ready(i_rdy0), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rv0), .i_rsp_instr(i_ins0), .i_rsp_err(i_err0),
        .d_req_valid(d_vld0), .d_req_ready(d_rdy0), .d_req_wr(d_req_wr),
        .d_req_strb(d_req_strb), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rv0), .d_rsp_rdata(d_rd0), .d_rsp_err(d_err0));

    unified_mem #(.BASE_ADDR(BASE), .AW(16), .WAIT(3)) u3 (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_vld3), .i_req_ready(i_rdy3), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rv3), .i_rsp_instr(i_ins3), .i_rsp_err(i_err3),
        .d_req_valid(d_vld3), .d_req_ready(d_rdy3), .d_req_wr(d_req_wr),
        .d_req_strb(d_req_strb), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rv3), .d_rsp_rdata(d_rd3), .d_rsp_err(d_err3));

    unified_mem #(.BASE_ADDR(BASE), .AW(16), .WAIT(2)) u2 (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_vld2), .i_req_ready(i_rdy2), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rv2), .i_rsp_instr(i_ins2), .i_rsp_err(i_err2),
        .d_req_valid(d_vld2), .d_req_ready(d_rdy2), .d_req_wr(d_req_wr),
        .d_req_strb(d_req_strb), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rv2), .d_rsp_rdata(d_rd2), .d_rsp_err(d_err2));

    // Data transaction on the WAIT=0 instance; lat = negedges until the response (-1 = none).
    task automatic d_txn0(input logic wr, input logic [7:0] strb, input logic [63:0] addr,
                          input logic [63:0] wdata, output logic [63:0] rdata,
                          output logic err, output int lat);
        @(posedge clk); #1;
        d_vld0 = 1'b1; d_req_wr = wr; d_req_strb = strb; d_req_addr = addr; d_req_wdata = wdata;
        @(posedge clk); #1;
        d_vld0 = 1'b0;
        lat = -1; rdata = '0; err = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (d_rv0) begin
                lat = k; rdata = d_rd0; err = d_err0;
                break;
            end
        end
    endtask

    task automatic f_txn0(input logic [63:0] addr, output logic [31:0] instr,
                          output logic err, output int lat);
        @(posedge clk); #1;
        i_vld0 = 1'b1; i_req_addr = addr;
        @(posedge clk); #1;
        i_vld0 = 1'b0;
        lat = -1; instr = '0; err = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (i_rv0) begin
                lat = k; instr = i_ins0; err = i_err0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (i_rdy0 !== 1'b1 || d_rdy0 !== 1'b1) begin errors++; $display("FAIL reset_ready: i=%b d=%b want 1 1", i_rdy0, d_rdy0); end
        checks++; if (i_rv0 !== 1'b0 || d_rv0 !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: i=%b d=%b want 0 0", i_rv0, d_rv0); end
        checks++; if (i_ins0 !== 32'h0 || i_err0 !== 1'b0) begin errors++; $display("FAIL reset_i_rsp: instr=%h err=%b want 0 0", i_ins0, i_err0); end
        checks++; if (d_rd0 !== 64'h0 || d_err0 !== 1'b0) begin errors++; $display("FAIL reset_d_rsp: rdata=%h err=%b want 0 0", d_rd0, d_err0); end
        checks++; if (d_rdy3 !== 1'b1 || d_rdy2 !== 1'b1) begin errors++; $display("FAIL reset_ready_wait: u3=%b u2=%b want 1 1", d_rdy3, d_rdy2); end
    endtask

    task automatic test_fetch();
        logic [31:0] ins; logic e; int lat;
        u0.mem[0] = 8'h13; u0.mem[1] = 8'h05; u0.mem[2] = 8'h00; u0.mem[3] = 8'h00;
        f_txn0(BASE, ins, e, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL fetch_latency: got %0d want 1", lat); end
        checks++; if (ins !== 32'h0000_0513 || e !== 1'b0) begin errors++; $display("FAIL fetch_data: instr=%h err=%b want 00000513 0", ins, e); end
        @(negedge clk);
        checks++; if (i_rv0 !== 1'b0 || i_ins0 !== 32'h0) begin errors++; $display("FAIL fetch_pulse: valid=%b instr=%h want 0 0", i_rv0, i_ins0); end
    endtask

    task automatic test_write_read();
        logic [63:0] rd; logic e; int lat;
        d_txn0(1'b1, 8'h0F, BASE + 64'h10, 64'h1122_3344_5566_7788, rd, e, lat);
        checks++; if (lat !== 1 || e !== 1'b0 || rd !== 64'h0) begin errors++; $display("FAIL write_rsp: lat=%0d err=%b rdata=%h want 1 0 0", lat, e, rd); end
        d_txn0(1'b0, 8'hFF, BASE + 64'h10, 64'h0, rd, e, lat);
        checks++; if (rd !== 64'h0000_0000_5566_7788 || e !== 1'b0) begin errors++; $display("FAIL read_full: rdata=%h err=%b want 0000000055667788 0", rd, e); end
        d_txn0(1'b0, 8'h0C, BASE + 64'h10, 64'h0, rd, e, lat);
        checks++; if (rd !== 64'h0000_0000_5566_0000) begin errors++; $display("FAIL read_masked: rdata=%h want 0000000055660000", rd); end
        d_txn0(1'b1, 8'h00, BASE + 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, rd, e, lat);
        checks++; if (e !== 1'b0 || u0.mem[16] !== 8'h88) begin errors++; $display("FAIL strb0_noop: err=%b byte=%h want 0 88", e, u0.mem[16]); end
    endtask

    task automatic test_errors();
        logic [63:0] rd; logic [31:0] ins; logic e; int lat;
        f_txn0(BASE + 64'h2, ins, e, lat);
        checks++; if (e !== 1'b1 || ins !== 32'h0) begin errors++; $display("FAIL fetch_misaligned: err=%b instr=%h want 1 0", e, ins); end
        d_txn0(1'b0, 8'hFF, 64'h7FFF_FFF8, 64'h0, rd, e, lat);
        checks++; if (e !== 1'b1 || rd !== 64'h0) begin errors++; $display("FAIL read_below: err=%b rdata=%h want 1 0", e, rd); end
        d_txn0(1'b0, 8'h01, BASE + 64'h1_0000, 64'h0, rd, e, lat);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL read_above: err=%b want 1", e); end
        for (int a = 16'hFFFC; a <= 16'hFFFF; a++) u0.mem[a] = 8'h5A;
        d_txn0(1'b1, 8'hFF, TOPW, 64'h0102_0304_0506_0708, rd, e, lat);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL write_top_oob: err=%b want 1", e); end
        checks++; if (u0.mem[16'hFFFC] !== 8'h5A || u0.mem[16'hFFFF] !== 8'h5A || u0.mem[0] !== 8'h13)
            begin errors++; $display("FAIL write_top_nowrap: %h %h %h want 5a 5a 13", u0.mem[16'hFFFC], u0.mem[16'hFFFF], u0.mem[0]); end
        d_txn0(1'b1, 8'h0F, TOPW, 64'h0000_0000_DEAD_BEEF, rd, e, lat);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL write_top_fit: err=%b want 0", e); end
        f_txn0(TOPW, ins, e, lat);
        checks++; if (e !== 1'b0 || ins !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fetch_top: err=%b instr=%h want 0 deadbeef", e, ins); end
    endtask

    // WAIT=3: accept at edge N, response in the cycle after edge N+3, re-accept at edge N+5.
    task automatic test_back_to_back();
        u3.mem[16'h10] = 8'hA5;
        for (int a = 16'h11; a <= 16'h17; a++) u3.mem[a] = 8'h00;
        @(posedge clk); #1;
        d_vld3 = 1'b1; d_req_wr = 1'b0; d_req_strb = 8'hFF; d_req_addr = BASE + 64'h10;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++; if (d_rdy3 !== (k == 5)) begin errors++; $display("FAIL b2b_ready_c%0d: got %b want %b", k, d_rdy3, (k == 5)); end
            checks++; if (d_rv3 !== (k == 4)) begin errors++; $display("FAIL b2b_valid_c%0d: got %b want %b", k, d_rv3, (k == 4)); end
            if (k == 4) begin
                checks++; if (d_rd3 !== 64'h0000_0000_0000_00A5) begin errors++; $display("FAIL b2b_rdata: got %h want a5", d_rd3); end
            end
        end
        @(posedge clk); #1;
        d_vld3 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++; if (d_rv3 !== (k == 4) || d_rdy3 !== 1'b0) begin errors++; $display("FAIL b2b_second_c%0d: valid=%b ready=%b", k, d_rv3, d_rdy3); end
        end
    endtask

    task automatic test_same_edge();
        logic [31:0] ins; logic e; int lat;
        @(posedge clk); #1;
        i_vld0 = 1'b1; i_req_addr = BASE;
        d_vld0 = 1'b1; d_req_wr = 1'b1; d_req_strb = 8'h01; d_req_addr = BASE; d_req_wdata = 64'hAA;
        @(posedge clk); #1;
        i_vld0 = 1'b0; d_vld0 = 1'b0;
        @(negedge clk);
        checks++; if (i_rv0 !== 1'b1 || i_ins0 !== 32'h0000_0513) begin errors++; $display("FAIL same_edge_old: valid=%b instr=%h want 1 00000513", i_rv0, i_ins0); end
        checks++; if (d_rv0 !== 1'b1 || d_err0 !== 1'b0) begin errors++; $display("FAIL same_edge_wr: valid=%b err=%b want 1 0", d_rv0, d_err0); end
        f_txn0(BASE, ins, e, lat);
        checks++; if (ins !== 32'h0000_05AA) begin errors++; $display("FAIL same_edge_new: instr=%h want 000005aa", ins); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        for (int a = 16'h20; a <= 16'h27; a++) u2.mem[a] = 8'h33;
        @(posedge clk); #1;
        d_vld2 = 1'b1; d_req_wr = 1'b1; d_req_strb = 8'hFF; d_req_addr = BASE + 64'h20; d_req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1;
        d_vld2 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (d_rdy2 !== 1'b1 || d_rv2 !== 1'b0) begin errors++; $display("FAIL midreset_hold: ready=%b valid=%b want 1 0", d_rdy2, d_rv2); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (d_rv2) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midreset_no_rsp: %0d pulses want 0", seen); end
        checks++; if (d_rdy2 !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b want 1", d_rdy2); end
        for (int a = 16'h20; a <= 16'h27; a++) begin
            checks++; if (u2.mem[a] !== 8'h33) begin errors++; $display("FAIL midreset_mem_%0h: got %h want 33", a, u2.mem[a]); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        i_vld0 = 0; d_vld0 = 0; i_vld3 = 0; d_vld3 = 0; i_vld2 = 0; d_vld2 = 0;
        i_req_addr = '0; d_req_addr = '0; d_req_wdata = '0; d_req_wr = 0; d_req_strb = '0;
        for (int a = 0; a < 65536; a++) begin
            u0.mem[a] = 8'h00; u3.mem[a] = 8'h00; u2.mem[a] = 8'h00;
        end
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_fetch();
        test_write_read();
        test_errors();
        test_back_to_back();
        test_same_edge();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
